health_tracker: RTL and testbench
=================================

HEALTH_TRACKER -- requirements
Module: health_tracker

Interface
REQ-001 Parameter MAX_HEALTH, default 3: starting and ceiling health value; legal range 1..255.
REQ-002 Parameter INVULN_CYCLES, default 3: length of the post-hit invulnerability window in Clk cycles; legal range 1..1023.
REQ-003 Parameter CLEAR_REQ, default 1: 1 = window counts only cycles with collision low; 0 = window is a plain timer.
REQ-004 Parameter AMT_W, default 2: width of dmgAmt and healAmt.
REQ-005 Derived HW = $clog2(MAX_HEALTH+1): width of healthCount.
REQ-006 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 Reset_n  input  1  synchronous, active-low reset.
REQ-008 collision  input  1  level; high while the player overlaps a hazard.
REQ-009 dmgAmt  input  AMT_W  damage applied per accepted hit.
REQ-010 heal  input  1  single-cycle pickup pulse.
REQ-011 healAmt  input  AMT_W  health restored per heal pulse.
REQ-012 restart  input  1  single-cycle request to begin a new round.
REQ-013 healthCount  output  HW  current health.
REQ-014 invuln  output  1  high while the invulnerability window is active.
REQ-015 hitPulse  output  1  one-cycle strobe when damage is applied.
REQ-016 gameEnd  output  1  high while health is 0.

Function
REQ-017 States: IDLE, ALIVE, INVULN, DEAD; all outputs are registered.
REQ-018 IDLE -> ALIVE unconditionally on the next cycle; healthCount = MAX_HEALTH in IDLE.
REQ-019 The block keeps a registered copy of collision (colPrev); a hit event = collision & ~colPrev.
REQ-020 Hit acceptance: in ALIVE only, a hit event with dmgAmt != 0; hits in IDLE/INVULN/DEAD and zero-damage hits are ignored, with no state or health change.
REQ-021 On an accepted hit: new health = max(0, health - dmgAmt) (+ heal term per REQ-024); hitPulse = 1 for exactly that next cycle.
REQ-022 After an accepted hit, if new health = 0: next state DEAD; else next state INVULN, window counter loaded with INVULN_CYCLES-1, invuln = 1.
REQ-023 INVULN, CLEAR_REQ=1: a cycle with collision high reloads the counter to INVULN_CYCLES-1; a cycle with collision low decrements it; counter = 0 with collision low -> ALIVE. CLEAR_REQ=0: decrement every cycle regardless of collision; counter = 0 -> ALIVE.
REQ-024 Heal: in ALIVE or INVULN, heal adds healAmt saturating at MAX_HEALTH; ignored in IDLE and DEAD.
REQ-025 Same-cycle hit and heal in ALIVE: result = clamp(health - dmgAmt + healAmt, 0, MAX_HEALTH), computed at width HW+AMT_W+1; DEAD only if the result is 0.
REQ-026 A collision held continuously across the ALIVE re-entry does not cause a hit (no rising edge); a new rising edge is required.
REQ-027 DEAD: healthCount = 0, gameEnd = 1, invuln = 0; held until restart.
REQ-028 restart in any state: next state IDLE, healthCount = MAX_HEALTH, counter = 0, invuln = 0, gameEnd = 0; restart overrides same-cycle hit and heal.
REQ-029 gameEnd = 1 if and only if the state is DEAD.

Reset
REQ-030 Reset_n low at a rising Clk edge forces: state IDLE, healthCount = MAX_HEALTH, invuln = 0, hitPulse = 0, gameEnd = 0, counter = 0, colPrev = 0.
REQ-031 Reset takes priority over every input, including in mid-window and in DEAD.

Verification (MAX_HEALTH=3, INVULN_CYCLES=3, CLEAR_REQ=1, AMT_W=2)
REQ-032 Reset, then idle -> IDLE for 1 cycle, then ALIVE; healthCount = 3; all strobes are 0.
REQ-033 collision 0->1 with dmgAmt = 1, held 5 cycles, then low -> healthCount = 2, one hitPulse, invuln high until 3 consecutive low cycles, then ALIVE with no second hit.
REQ-034 Three separated hits with dmgAmt = 1 -> healthCount 2, 1, 0; gameEnd = 1 after the third; a later collision edge has no effect; restart -> healthCount = 3, gameEnd = 0.
REQ-035 healthCount = 1; same-cycle hit (dmgAmt = 2) and heal (healAmt = 3) -> healthCount = 2, INVULN; heal at healthCount = 3 -> stays 3.
REQ-036 CLEAR_REQ=0, collision held high -> INVULN exits after exactly 3 cycles; dmgAmt = 3 at health 2 -> healthCount = 0, DEAD.
REQ-037 Reset_n low in mid-INVULN, same cycle as a heal -> next cycle IDLE, healthCount = 3, invuln = 0.

Source files
------------

// File: rtl/health_tracker.sv
// Player health tracker: hit/heal accounting, post-hit invulnerability window and game-over flag.
// All outputs are registered; restart and reset both return the round to IDLE at full health.
module health_tracker #(
    parameter int MAX_HEALTH    = 3,
    parameter int INVULN_CYCLES = 3,
    parameter int CLEAR_REQ     = 1,
    parameter int AMT_W         = 2,
    parameter int HW            = $clog2(MAX_HEALTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             collision,
    input  logic [AMT_W-1:0] dmgAmt,
    input  logic             heal,
    input  logic [AMT_W-1:0] healAmt,
    input  logic             restart,
    output logic [HW-1:0]    healthCount,
    output logic             invuln,
    output logic             hitPulse,
    output logic             gameEnd
);

    // state  | meaning
    // IDLE   | round start, health forced to MAX_HEALTH, lasts one cycle
    // ALIVE  | hits and heals accepted
    // INVULN | post-hit window, hits ignored, heals accepted
    // DEAD   | health 0, waits for restart
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ALIVE  = 2'd1;
    localparam logic [1:0] INVULN = 2'd2;
    localparam logic [1:0] DEAD   = 2'd3;

    localparam int CW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
    localparam int SW = HW + AMT_W + 1;

    localparam logic [HW-1:0] HMAX  = HW'(MAX_HEALTH);
    localparam logic [CW-1:0] CLOAD = CW'(INVULN_CYCLES - 1);
    localparam logic [SW-1:0] SMAX  = SW'(MAX_HEALTH);

    logic [1:0]    state, state_nx;
    logic [HW-1:0] health_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          colPrev;
    logic          hitPulse_nx;
    logic          hit_ok;
    logic [SW-1:0] up, down, diff, sum;

    assign hit_ok = collision & ~colPrev & (dmgAmt != '0);

    // Add first, then subtract, so a same-cycle heal can offset the damage before clamping at 0.
    assign up   = SW'(healthCount) + (heal ? SW'(healAmt) : '0);
    assign down = (state == ALIVE && hit_ok) ? SW'(dmgAmt) : '0;
    assign diff = up - down;
    assign sum  = (up <= down) ? '0 : ((diff > SMAX) ? SMAX : diff);

    always_comb begin
        state_nx    = state;
        health_nx   = healthCount;
        cnt_nx      = cnt;
        hitPulse_nx = 1'b0;
        case (state)
            IDLE: begin
                state_nx  = ALIVE;
                health_nx = HMAX;
            end
            ALIVE: begin
                health_nx = HW'(sum);
                if (hit_ok) begin
                    hitPulse_nx = 1'b1;
                    if (sum == '0) begin
                        state_nx = DEAD;
                    end else begin
                        state_nx = INVULN;
                        cnt_nx   = CLOAD;
                    end
                end
            end
            INVULN: begin
                health_nx = HW'(sum);
                if (CLEAR_REQ != 0 && collision) begin
                    cnt_nx = CLOAD;
                end else if (cnt == '0) begin
                    state_nx = ALIVE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            DEAD: begin
                health_nx = '0;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n || restart) begin
            state       <= IDLE;
            healthCount <= HMAX;
            cnt         <= '0;
            invuln      <= 1'b0;
            hitPulse    <= 1'b0;
            gameEnd     <= 1'b0;
        end else begin
            state       <= state_nx;
            healthCount <= health_nx;
            cnt         <= cnt_nx;
            invuln      <= (state_nx == INVULN);
            hitPulse    <= hitPulse_nx;
            gameEnd     <= (state_nx == DEAD);
        end
    end

    // Edge detector keeps tracking across restart so a held collision never re-triggers.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            colPrev <= 1'b0;
        end else begin
            colPrev <= collision;
        end
    end

endmodule

// File: tb/tb_health_tracker.sv
// Bench for health_tracker: two instances (window cleared by collision / plain timer) driven
// with the same stimulus, checked each cycle against a behavioural model via expectation queues.
module tb_health_tracker;

    localparam int MAXH = 3;
    localparam int INV  = 3;

    typedef struct packed {
        logic [1:0] h;
        logic       inv;
        logic       hp;
        logic       ge;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       collision;
    logic [1:0] dmgAmt;
    logic       heal;
    logic [1:0] healAmt;
    logic       restart;

    logic [1:0] h0, h1;
    logic       inv0, inv1, hp0, hp1, ge0, ge1;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    int m_st [2];
    int m_h  [2];
    int m_cnt[2];
    int m_cp [2];
    int m_hp [2];

    exp_t q0[$];
    exp_t q1[$];

    health_tracker #(.MAX_HEALTH(MAXH), .INVULN_CYCLES(INV), .CLEAR_REQ(1), .AMT_W(2)) u0 (
        .Clk(Clk), .Reset_n(Reset_n), .collision(collision), .dmgAmt(dmgAmt),
        .heal(heal), .healAmt(healAmt), .restart(restart),
        .healthCount(h0), .invuln(inv0), .hitPulse(hp0), .gameEnd(ge0)
    );

    health_tracker #(.MAX_HEALTH(MAXH), .INVULN_CYCLES(INV), .CLEAR_REQ(0), .AMT_W(2)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .collision(collision), .dmgAmt(dmgAmt),
        .heal(heal), .healAmt(healAmt), .restart(restart),
        .healthCount(h1), .invuln(inv1), .hitPulse(hp1), .gameEnd(ge1)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL [%s] %s: got %0d, expected %0d", phase, tag, got, exp);
        end
    endtask

    // States: 0 IDLE, 1 ALIVE, 2 INVULN, 3 DEAD
    task automatic model_step(input int k, input bit clr);
        bit is_hit;
        int r;
        is_hit  = collision && (m_cp[k] == 0) && (dmgAmt != 0);
        m_cp[k] = Reset_n ? int'(collision) : 0;
        m_hp[k] = 0;
        if (!Reset_n || restart) begin
            m_st[k]  = 0;
            m_h[k]   = MAXH;
            m_cnt[k] = 0;
        end else begin
            case (m_st[k])
                0: begin
                    m_st[k] = 1;
                    m_h[k]  = MAXH;
                end
                1: begin
                    r = m_h[k] + (heal ? int'(healAmt) : 0) - (is_hit ? int'(dmgAmt) : 0);
                    if (r < 0) r = 0;
                    if (r > MAXH) r = MAXH;
                    m_h[k] = r;
                    if (is_hit) begin
                        m_hp[k] = 1;
                        if (r == 0) m_st[k] = 3;
                        else begin
                            m_st[k]  = 2;
                            m_cnt[k] = INV - 1;
                        end
                    end
                end
                2: begin
                    if (heal) m_h[k] = (m_h[k] + int'(healAmt) > MAXH) ? MAXH : m_h[k] + int'(healAmt);
                    if (clr && collision) m_cnt[k] = INV - 1;
                    else if (m_cnt[k] == 0) m_st[k] = 1;
                    else m_cnt[k] = m_cnt[k] - 1;
                end
                default: m_h[k] = 0;
            endcase
        end
    endtask

    task automatic step();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            model_step(k, k == 0);
            e.h   = 2'(m_h[k]);
            e.inv = (m_st[k] == 2);
            e.hp  = (m_hp[k] != 0);
            e.ge  = (m_st[k] == 3);
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
        end
        @(posedge Clk);
        #1;
        e = q0.pop_front();
        chk("u0.healthCount", h0, e.h);
        chk("u0.invuln", inv0, e.inv);
        chk("u0.hitPulse", hp0, e.hp);
        chk("u0.gameEnd", ge0, e.ge);
        e = q1.pop_front();
        chk("u1.healthCount", h1, e.h);
        chk("u1.invuln", inv1, e.inv);
        chk("u1.hitPulse", hp1, e.hp);
        chk("u1.gameEnd", ge1, e.ge);
    endtask

    task automatic hit(input int d);
        collision = 1'b1;
        dmgAmt    = 2'(d);
        step();
        collision = 1'b0;
        repeat (4) step();
    endtask

    task automatic new_round();
        restart = 1'b1;
        step();
        restart = 1'b0;
        step();
    endtask

    initial begin
        Reset_n = 1'b0; collision = 1'b0; dmgAmt = 2'd0;
        heal = 1'b0; healAmt = 2'd0; restart = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_h[k] = MAXH; m_cnt[k] = 0; m_cp[k] = 0; m_hp[k] = 0;
        end

        phase = "reset";
        repeat (2) step();
        chk("reset health", h0, 3);
        chk("reset gameEnd", ge0, 0);

        // collision rising during the single IDLE cycle is ignored
        phase = "idle";
        Reset_n = 1'b1; collision = 1'b1; dmgAmt = 2'd1;
        step();
        chk("idle hit ignored", h0, 3);
        step();
        chk("held collision no hit", h0, 3);
        collision = 1'b0;
        step();

        phase = "held_hit";
        collision = 1'b1; dmgAmt = 2'd1;
        repeat (3) step();
        chk("held health", h0, 2);
        chk("timer window still on", inv1, 1);
        step();
        chk("timer window exit after 3", inv1, 0);
        chk("cleared window held on", inv0, 1);
        step();
        collision = 1'b0;
        repeat (2) step();
        chk("window before 3rd low", inv0, 1);
        step();
        chk("window after 3rd low", inv0, 0);
        repeat (2) step();
        chk("no second hit", h0, 2);

        phase = "three_hits";
        new_round();
        hit(1); chk("hit1", h0, 2);
        hit(1); chk("hit2", h0, 1);
        hit(1); chk("hit3", h0, 0); chk("dead gameEnd", ge0, 1);
        hit(1); chk("dead ignores hit", h0, 0); chk("dead holds", ge0, 1);
        new_round();
        chk("restart health", h0, 3);
        chk("restart gameEnd", ge0, 0);

        phase = "hit_heal";
        hit(1); hit(1);
        chk("setup health 1", h0, 1);
        hit(0);
        chk("zero dmg ignored", h0, 1);
        collision = 1'b1; dmgAmt = 2'd2; heal = 1'b1; healAmt = 2'd3;
        step();
        chk("hit+heal health", h0, 2);
        chk("hit+heal invuln", inv0, 1);
        heal = 1'b0; collision = 1'b0;
        repeat (4) step();
        heal = 1'b1; healAmt = 2'd1;
        step();
        chk("heal to max", h0, 3);
        step();
        chk("heal saturates", h0, 3);
        heal = 1'b0;

        phase = "big_hit";
        new_round();
        hit(1);
        hit(3);
        chk("dmg3 at 2 health", h0, 0);
        chk("dmg3 dead", ge0, 1);
        chk("dmg3 dead u1", ge1, 1);

        phase = "reset_mid_window";
        new_round();
        collision = 1'b1; dmgAmt = 2'd1;
        step();
        collision = 1'b0;
        step();
        chk("mid window", inv0, 1);
        Reset_n = 1'b0; heal = 1'b1; healAmt = 2'd1;
        step();
        chk("reset health", h0, 3);
        chk("reset invuln", inv0, 0);
        Reset_n = 1'b1; heal = 1'b0;
        step();

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) collision = ~collision;
            dmgAmt  = 2'($urandom_range(0, 3));
            heal    = ($urandom_range(0, 5) == 0);
            healAmt = 2'($urandom_range(0, 3));
            restart = ($urandom_range(0, 39) == 0);
            Reset_n = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
